// File: rtl/screen_fade_fx.sv
// screen_fade_fx: frame-synchronous fade and hit-flash, RGB332 to 4:4:4 DAC.
// Define FLASH_FX_EN to build the white hit-flash state.
module screen_fade_fx #(
  parameter int FADE_STEP_FRAMES = 4,
  parameter int FLASH_FRAMES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic [7:0] RGBIn,
  input  logic       hsyncIn,
  input  logic       vsyncIn,
  input  logic       blankNIn,
  input  logic       fade_out_req,
  input  logic       fade_in_req,
  input  logic       flash_req,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic       hsync,
  output logic       vsync,
  output logic       blankN,
  output logic       busy,
  output logic       black
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_DARK     = 3'd2,
    S_FADE_IN  = 3'd3
`ifdef FLASH_FX_EN
    , S_FLASH  = 3'd4
`endif
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);
`ifdef FLASH_FX_EN
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
  logic pend_q, pend_d;
`else
  logic unused_flash;
  assign unused_flash = flash_req ^ FLASH_FRAMES[0];
`endif

  state_t     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d, bl1_q, bl1_d;
  logic [3:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic       hs2_q, hs2_d, vs2_q, vs2_d, bl2_q, bl2_d;
  logic       white;

  function automatic logic [3:0] scale(input logic [3:0] c,
                                       input logic [3:0] lvl);
    logic [7:0] p;
    p = {4'd0, c} * {4'd0, lvl};
    return 4'(p >> 3);
  endfunction

  // Fade/flash state machine: level only moves on startOfFrame.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
`ifdef FLASH_FX_EN
    pend_d  = pend_q;
`endif
    if (startOfFrame) cnt_d = cnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        level_d = 4'd8;
        if (fade_out_req) begin
          state_d = S_FADE_OUT;
          cnt_d   = '0;
`ifdef FLASH_FX_EN
          pend_d  = 1'b0;
`endif
        end
`ifdef FLASH_FX_EN
        else if (startOfFrame && pend_q) begin
          state_d = S_FLASH;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (flash_req) begin
          pend_d = 1'b1;
        end
`endif
      end
      S_FADE_OUT: begin
        if (fade_in_req && !fade_out_req) begin
          state_d = S_FADE_IN;
          cnt_d   = '0;
        end else if (startOfFrame && cnt_q >= STEP_LAST) begin
          cnt_d = '0;
          if (level_q <= 4'd1) begin
            level_d = 4'd0;
            state_d = S_DARK;
          end else begin
            level_d = level_q - 4'd1;
          end
        end
      end
      S_DARK: begin
        level_d = 4'd0;
        if (fade_in_req) begin
          state_d = S_FADE_IN;
          cnt_d   = '0;
        end
      end
      S_FADE_IN: begin
        if (fade_out_req) begin
          state_d = S_FADE_OUT;
          cnt_d   = '0;
        end else if (startOfFrame && cnt_q >= STEP_LAST) begin
          cnt_d = '0;
          if (level_q >= 4'd7) begin
            level_d = 4'd8;
            state_d = S_IDLE;
          end else begin
            level_d = level_q + 4'd1;
          end
        end
      end
`ifdef FLASH_FX_EN
      S_FLASH: begin
        level_d = 4'd8;
        if (startOfFrame && cnt_q >= FLASH_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        level_d = 4'd8;
        cnt_d   = '0;
      end
    endcase
  end

  // Two-stage pixel path: expand, then scale/blank.
  always_comb begin
    r1_d  = {RGBIn[7:5], RGBIn[7]};
    g1_d  = {RGBIn[4:2], RGBIn[4]};
    b1_d  = {RGBIn[1:0], RGBIn[1:0]};
    hs1_d = hsyncIn;
    vs1_d = vsyncIn;
    bl1_d = blankNIn;
`ifdef FLASH_FX_EN
    white = (state_q == S_FLASH);
`else
    white = 1'b0;
`endif
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    bl2_d = bl1_q;
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (bl1_q) begin
      red_d = scale(white ? 4'hF : r1_q, level_q);
      grn_d = scale(white ? 4'hF : g1_q, level_q);
      blu_d = scale(white ? 4'hF : b1_q, level_q);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= 4'd8;
      cnt_q   <= '0;
`ifdef FLASH_FX_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
`ifdef FLASH_FX_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // Pipeline registers, flushed to idle-bus values on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q  <= '0;
      g1_q  <= '0;
      b1_q  <= '0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      bl1_q <= 1'b0;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      bl2_q <= 1'b0;
    end else begin
      r1_q  <= r1_d;
      g1_q  <= g1_d;
      b1_q  <= b1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      bl1_q <= bl1_d;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      bl2_q <= bl2_d;
    end
  end

  assign Red    = red_q;
  assign Green  = grn_q;
  assign Blue   = blu_q;
  assign hsync  = hs2_q;
  assign vsync  = vs2_q;
  assign blankN = bl2_q;
  assign busy   = (state_q != S_IDLE);
  assign black  = (state_q == S_DARK);

endmodule

// File: tb/tb_screen_fade_fx.sv
// tb_screen_fade_fx: directed checks of screen_fade_fx, FADE_STEP_FRAMES=2.
// Define FLASH_FX_EN to also exercise the hit-flash.
module tb_screen_fade_fx;
  logic       clk = 1'b0;
  logic       reset, startOfFrame;
  logic [7:0] RGBIn;
  logic       hsyncIn, vsyncIn, blankNIn;
  logic       fade_out_req, fade_in_req, flash_req;
  logic [3:0] Red, Green, Blue;
  logic       hsync, vsync, blankN, busy, black;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  screen_fade_fx #(.FADE_STEP_FRAMES(2), .FLASH_FRAMES(8)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .RGBIn(RGBIn), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
    .blankNIn(blankNIn), .fade_out_req(fade_out_req),
    .fade_in_req(fade_in_req), .flash_req(flash_req),
    .Red(Red), .Green(Green), .Blue(Blue), .hsync(hsync),
    .vsync(vsync), .blankN(blankN), .busy(busy), .black(black)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      cyc(3);
    end
  endtask

  task automatic pulse_req(input logic fo, input logic fi, input logic fl);
    fade_out_req = fo;
    fade_in_req  = fi;
    flash_req    = fl;
    @(negedge clk);
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    flash_req    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    checks++;
    if (Red !== 4'd0 || Green !== 4'd0 || Blue !== 4'd0 ||
        hsync !== 1'b1 || vsync !== 1'b1 || blankN !== 1'b0 ||
        busy !== 1'b0 || black !== 1'b0) begin
      errors++;
      $display("FAIL reset: rgb=%h%h%h h=%b v=%b bn=%b busy=%b blk=%b want 000 1 1 0 0 0",
               Red, Green, Blue, hsync, vsync, blankN, busy, black);
    end
    reset = 1'b0;
    cyc(3);
  endtask

  task automatic test_expand();
    checks++;
    if (Red !== 4'hF || Green !== 4'hF || Blue !== 4'hF) begin
      errors++;
      $display("FAIL expand_ff0: rgb=%h%h%h want fff", Red, Green, Blue);
    end
    RGBIn = 8'b100_010_01;
    cyc(1);
    checks++;
    if (Red !== 4'hF) begin
      errors++;
      $display("FAIL latency1: red=%h want f", Red);
    end
    cyc(1);
    checks++;
    if (Red !== 4'd9 || Green !== 4'd4 || Blue !== 4'd5) begin
      errors++;
      $display("FAIL expand_945: rgb=%h%h%h want 945", Red, Green, Blue);
    end
    blankNIn = 1'b0;
    cyc(2);
    checks++;
    if (Red !== 4'd0 || Green !== 4'd0 || Blue !== 4'd0 || blankN !== 1'b0) begin
      errors++;
      $display("FAIL blank_idle: rgb=%h%h%h bn=%b want 000 0", Red, Green, Blue, blankN);
    end
    blankNIn = 1'b1;
    RGBIn = 8'hFF;
    cyc(2);
    checks++;
    if (Red !== 4'hF || Green !== 4'hF || Blue !== 4'hF) begin
      errors++;
      $display("FAIL expand_ff: rgb=%h%h%h want fff", Red, Green, Blue);
    end
  endtask

  task automatic test_sync(input string tag);
    logic h [0:23];
    logic v [0:23];
    logic b [0:23];
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (hsync !== h[i-2] || vsync !== v[i-2] || blankN !== b[i-2]) begin
          errors++;
          $display("FAIL sync_%s[%0d]: h=%b v=%b bn=%b want %b %b %b", tag, i,
                   hsync, vsync, blankN, h[i-2], v[i-2], b[i-2]);
        end
      end
      h[i] = 1'($urandom_range(0, 1));
      v[i] = 1'($urandom_range(0, 1));
      b[i] = 1'($urandom_range(0, 1));
      hsyncIn  = h[i];
      vsyncIn  = v[i];
      blankNIn = b[i];
    end
    hsyncIn  = 1'b0;
    vsyncIn  = 1'b0;
    blankNIn = 1'b1;
    cyc(2);
  endtask

  task automatic test_fade_out();
    RGBIn = 8'hFF;
    pulse_req(1'b1, 1'b0, 1'b0);
    frames(4);
    checks++;
    if (Red !== 4'd11 || busy !== 1'b1 || black !== 1'b0) begin
      errors++;
      $display("FAIL fade_out_l6: red=%h busy=%b blk=%b want b 1 0", Red, busy, black);
    end
    frames(4);
    checks++;
    if (Red !== 4'd7 || Green !== 4'd7 || Blue !== 4'd7) begin
      errors++;
      $display("FAIL fade_out_l4: rgb=%h%h%h want 777", Red, Green, Blue);
    end
    frames(8);
    checks++;
    if (Red !== 4'd0 || Green !== 4'd0 || Blue !== 4'd0 ||
        black !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fade_out_dark: rgb=%h%h%h blk=%b busy=%b want 000 1 1",
               Red, Green, Blue, black, busy);
    end
  endtask

  task automatic test_fade_in();
    pulse_req(1'b0, 1'b1, 1'b0);
    frames(8);
    checks++;
    if (Red !== 4'd7 || busy !== 1'b1 || black !== 1'b0) begin
      errors++;
      $display("FAIL fade_in_l4: red=%h busy=%b blk=%b want 7 1 0", Red, busy, black);
    end
    test_sync("fade_in");
    frames(8);
    checks++;
    if (Red !== 4'hF || Green !== 4'hF || Blue !== 4'hF ||
        busy !== 1'b0 || black !== 1'b0) begin
      errors++;
      $display("FAIL fade_in_full: rgb=%h%h%h busy=%b blk=%b want fff 0 0",
               Red, Green, Blue, busy, black);
    end
  endtask

  task automatic test_priority();
    pulse_req(1'b1, 1'b0, 1'b0);
    frames(4);
    checks++;
    if (Red !== 4'd11) begin
      errors++;
      $display("FAIL prio_l6: red=%h want b", Red);
    end
    pulse_req(1'b1, 1'b1, 1'b0);
    frames(2);
    checks++;
    if (Red !== 4'd9 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_out_wins: red=%h busy=%b want 9 1", Red, busy);
    end
    pulse_req(1'b0, 1'b1, 1'b0);
    frames(2);
    checks++;
    if (Red !== 4'd11) begin
      errors++;
      $display("FAIL rise_l6: red=%h want b", Red);
    end
    frames(2);
    checks++;
    if (Red !== 4'd13) begin
      errors++;
      $display("FAIL rise_l7: red=%h want d", Red);
    end
    frames(2);
    checks++;
    if (Red !== 4'hF || busy !== 1'b0) begin
      errors++;
      $display("FAIL rise_l8: red=%h busy=%b want f 0", Red, busy);
    end
  endtask

`ifdef FLASH_FX_EN
  task automatic test_flash();
    RGBIn = 8'h00;
    pulse_req(1'b0, 1'b0, 1'b1);
    cyc(3);
    checks++;
    if (Red !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flash_pending: red=%h busy=%b want 0 0", Red, busy);
    end
    frames(1);
    checks++;
    if (Red !== 4'hF || Green !== 4'hF || Blue !== 4'hF || busy !== 1'b1) begin
      errors++;
      $display("FAIL flash_on: rgb=%h%h%h busy=%b want fff 1", Red, Green, Blue, busy);
    end
    frames(6);
    checks++;
    if (Red !== 4'hF || Green !== 4'hF || Blue !== 4'hF) begin
      errors++;
      $display("FAIL flash_hold: rgb=%h%h%h want fff", Red, Green, Blue);
    end
    blankNIn = 1'b0;
    frames(1);
    checks++;
    if (Red !== 4'd0 || Green !== 4'd0 || Blue !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flash_blank: rgb=%h%h%h busy=%b want 000 1", Red, Green, Blue, busy);
    end
    blankNIn = 1'b1;
    cyc(2);
    checks++;
    if (Red !== 4'hF) begin
      errors++;
      $display("FAIL flash_last: red=%h want f", Red);
    end
    frames(1);
    checks++;
    if (Red !== 4'd0 || Green !== 4'd0 || Blue !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flash_end: rgb=%h%h%h busy=%b want 000 0", Red, Green, Blue, busy);
    end
    pulse_req(1'b0, 1'b0, 1'b1);
    pulse_req(1'b1, 1'b0, 1'b0);
    frames(1);
    checks++;
    if (Red !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flash_cancel: red=%h busy=%b want 0 1", Red, busy);
    end
    pulse_req(1'b0, 1'b0, 1'b1);
    frames(2);
    checks++;
    if (Red !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flash_in_fade: red=%h busy=%b want 0 1", Red, busy);
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    RGBIn = 8'hFF;
    cyc(3);
  endtask
`else
  task automatic test_flash();
    RGBIn = 8'h00;
    pulse_req(1'b0, 1'b0, 1'b1);
    frames(2);
    checks++;
    if (Red !== 4'd0 || Green !== 4'd0 || Blue !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flash_off: rgb=%h%h%h busy=%b want 000 0", Red, Green, Blue, busy);
    end
    RGBIn = 8'hFF;
    cyc(2);
  endtask
`endif

  task automatic test_reset_mid();
    RGBIn = 8'hFF;
    pulse_req(1'b1, 1'b0, 1'b0);
    frames(10);
    checks++;
    if (Red !== 4'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_l3: red=%h busy=%b want 5 1", Red, busy);
    end
    hsyncIn = 1'b0;
    vsyncIn = 1'b0;
    reset = 1'b1;
    cyc(1);
    checks++;
    if (busy !== 1'b0 || black !== 1'b0 || Red !== 4'd0 ||
        hsync !== 1'b1 || vsync !== 1'b1 || blankN !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b blk=%b red=%h h=%b v=%b bn=%b want 0 0 0 1 1 0",
               busy, black, Red, hsync, vsync, blankN);
    end
    reset = 1'b0;
    cyc(1);
    checks++;
    if (Red !== 4'd0 || hsync !== 1'b1 || blankN !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush: red=%h h=%b bn=%b want 0 1 0", Red, hsync, blankN);
    end
    cyc(1);
    checks++;
    if (Red !== 4'hF || hsync !== 1'b0 || blankN !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_refill: red=%h h=%b bn=%b busy=%b want f 0 1 0",
               Red, hsync, blankN, busy);
    end
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    RGBIn        = 8'hFF;
    hsyncIn      = 1'b0;
    vsyncIn      = 1'b0;
    blankNIn     = 1'b1;
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    flash_req    = 1'b0;
    test_reset();
    test_expand();
    test_sync("idle");
    test_fade_out();
    test_sync("dark");
    test_fade_in();
    test_priority();
    test_flash();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
